mem_arbiter: RTL
================

# mem_arbiter

Unified memory bus arbiter between instruction fetch and the MEM stage. It owns the single external Wishbone-style bus and serialises fetch and load/store transactions onto it. It returns read data and one-cycle ready pulses to each requester, and raises `stallreq_if` / `stallreq_mem` to ctrl so the stall bus freezes the pipeline, including the EX/MEM register, while an access is outstanding. It has an ack watchdog and a flush path for exceptions.

## Interface
- `TIMEOUT`, default 255: cycles without `bus_ack` before a transaction is force-terminated (range 1..1023).
- `ERR_DATA`, default 32'hDEADBEEF: read data returned on timeout.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `if_req`  in  1  fetch request; held stable by the pipeline until `if_ready`.
- `if_addr`  in  32  fetch address.
- `if_rdata`  out  32  fetched word; valid while `if_ready`=1.
- `if_ready`  out  1  one-cycle completion pulse for fetch.
- `mem_req`  in  1  load/store request; stable until `mem_ready`.
- `mem_we`  in  1  1 = store.
- `mem_sel`  in  4  byte enables.
- `mem_addr`  in  32  data address.
- `mem_wdata`  in  32  store data.
- `mem_rdata`  out  32  load data; valid while `mem_ready`=1.
- `mem_ready`  out  1  one-cycle completion pulse for data.
- `flush`  in  1  exception flush from ctrl; suppresses pending ready pulses.
- `stallreq_if`  out  1  `if_req & ~if_ready` (combinational).
- `stallreq_mem`  out  1  `mem_req & ~mem_ready` (combinational).
- `bus_cyc`, `bus_stb`  out  1  transaction active (both driven identically).
- `bus_we`  out  1  write strobe.
- `bus_sel`  out  4  byte enables.
- `bus_adr`  out  32  address.
- `bus_dat_o`  out  32  write data.
- `bus_dat_i`  in  32  read data.
- `bus_ack`  in  1  slave completion; sampled only while `bus_stb`=1.
- `bus_err`  out  1  one-cycle pulse on watchdog timeout.

## Operation
- States: IDLE, BUSY_IF, BUSY_MEM.
- IDLE:
  - A requester is eligible only if its `req`=1 and its `ready` is 0 this cycle. This blocks re-issuing the access whose completion is being consumed.
  - Priority goes to MEM over IF, because MEM holds the older instruction.
  - On grant, register the address, we, sel and wdata onto the bus outputs, assert `bus_cyc`/`bus_stb`, clear the watchdog, and go to BUSY_MEM or BUSY_IF.
  - Fetch uses `bus_we`=0, `bus_sel`=4'hF, `bus_dat_o`=0.
- BUSY_x:
  - Bus outputs hold constant.
  - The watchdog increments each cycle without `bus_ack`.
  - On `bus_ack`: latch `bus_dat_i` into x_rdata, set x_ready for exactly one cycle, drop `bus_stb`/`bus_cyc`, and return to IDLE.
  - On watchdog == `TIMEOUT`-1 without ack: same as ack, but x_rdata=`ERR_DATA` and `bus_err` pulses with the ready pulse.
  - For stores, x_rdata is 0.
- Flush:
  - Any cycle with `flush`=1 sets a discard flag if a transaction is in flight.
  - The bus cycle still runs to ack or timeout; it is never aborted.
  - Completion then returns to IDLE with no ready pulse and rdata unchanged.
  - The discard flag clears on that completion.
  - `flush` in IDLE has no effect, and the ready pulse produced in the same cycle as `flush` is forced to 0.
- The arbiter never issues back-to-back without an IDLE cycle. The bus is always idle at least one cycle between transactions.
- Data regs hold their last value between pulses.

## Timing
- Reset (rst=0, async) clears everything:
  - state to IDLE;
  - `bus_cyc`, `bus_stb`, `bus_we`=0; `bus_sel`=0; `bus_adr`, `bus_dat_o`=0;
  - `if_ready`, `mem_ready`, `bus_err`=0; `if_rdata`, `mem_rdata`=0;
  - watchdog and discard flag cleared.
- Reset during BUSY drops `bus_stb` immediately, and no ready pulse follows.
- Latency:
  - Request in IDLE at cycle 0 puts `bus_stb` high at cycle 1.
  - The earliest ack is sampled at edge ending cycle 1, which gives ready at cycle 2.
  - Minimum 3 cycles request-to-ready; ack after k stb-cycles gives ready at cycle 1+k.
- Simultaneous `if_req` and `mem_req` in IDLE:
  - MEM is served first.
  - IF is granted in the cycle `mem_ready` is high, since IF is still eligible then; IF `bus_stb` rises the cycle after.
- Ack and timeout in the same cycle are treated as ack, with real data and no `bus_err`.
- The watchdog is 10 bits and saturates; it never wraps.

## Test plan
- Single fetch, slave acks the first stb cycle:
  - if_req at cycle 0 with if_addr=0x100 and bus_dat_i=0x24020005 gives `bus_adr`=0x100 at cycle 1 and `if_ready`=1 with `if_rdata`=0x24020005 at cycle 2.
  - `stallreq_if`=1 during cycles 0-1.
- Contention, both requests at cycle 0, ack latency 2:
  - MEM store (addr 0x2000, wdata 0xCAFEF00D, sel 4'b0011) is on the bus first, and `mem_ready` pulses at cycle 3.
  - IF `bus_stb` rises at cycle 4, and `if_ready` pulses at cycle 6.
- No re-issue:
  - Hold `mem_req` high through the `mem_ready` cycle.
  - Exactly one bus transaction occurs.
- Timeout with `TIMEOUT`=4 and no ack:
  - `mem_ready`, `bus_err`=1 and `mem_rdata`=0xDEADBEEF appear 5 cycles after the request.
  - `bus_stb` then drops.
- Flush mid-fetch:
  - Assert `flush` one cycle after `bus_stb` rises, with ack 3 cycles later.
  - No `if_ready` pulse and `if_rdata` unchanged.
  - A new `if_req` (addr 0x180) is then granted normally.
- Async reset mid-BUSY:
  - `bus_stb` drops without waiting for a clock edge, all outputs go to reset values, and there is no ready pulse after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction fetch and load/store accesses onto one
// external Wishbone-style bus. Each requester gets read data plus a one-cycle
// ready pulse, and a watchdog terminates a transaction the slave never acks.
//
// Handshake: a requester raises x_req and holds it (and its address/data)
// stable until the cycle x_ready=1; the arbiter pulses x_ready for exactly one
// cycle per completed access. On the bus side, bus_stb/bus_cyc stay high with
// constant address/data until bus_ack=1 (or the watchdog fires), and then drop
// for at least one cycle before the next transaction starts.
module mem_arbiter #(
   parameter int          TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [3:0]  mem_sel,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   input  logic        flush,
   output logic        stallreq_if,
   output logic        stallreq_mem,
   output logic        bus_cyc,
   output logic        bus_stb,
   output logic        bus_we,
   output logic [3:0]  bus_sel,
   output logic [31:0] bus_adr,
   output logic [31:0] bus_dat_o,
   input  logic [31:0] bus_dat_i,
   input  logic        bus_ack,
   output logic        bus_err,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUSY_IF  = 2'd1,
      BUSY_MEM = 2'd2
   } state_t;

   localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);
   localparam logic [9:0] WD_MAX  = 10'h3FF;

   state_t     state;
   logic [9:0] wd_cnt;
   logic       discard;
   logic       if_elig;
   logic       mem_elig;
   logic       timeout_hit;
   logic       done;

   // A requester whose ready pulse is visible this cycle is consuming that
   // completion, so it must not be granted again off the same request.
   assign if_elig      = if_req & ~if_ready;
   assign mem_elig     = mem_req & ~mem_ready;
   assign stallreq_if  = if_req & ~if_ready;
   assign stallreq_mem = mem_req & ~mem_ready;

   // Ack wins over a simultaneous watchdog expiry.
   assign timeout_hit = (wd_cnt == WD_LAST);
   assign done        = bus_ack | timeout_hit;

   assign bus_stb   = bus_cyc;
   assign dbg_state = state;

   // Arbitration FSM with registered bus outputs, ready pulses and read data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         bus_cyc   <= 1'b0;
         bus_we    <= 1'b0;
         bus_sel   <= 4'h0;
         bus_adr   <= 32'h0;
         bus_dat_o <= 32'h0;
         if_ready  <= 1'b0;
         mem_ready <= 1'b0;
         bus_err   <= 1'b0;
         if_rdata  <= 32'h0;
         mem_rdata <= 32'h0;
         wd_cnt    <= 10'h0;
         discard   <= 1'b0;
      end else begin
         if_ready  <= 1'b0;
         mem_ready <= 1'b0;
         bus_err   <= 1'b0;
         case (state)
            IDLE: begin
               // MEM holds the older instruction, so it wins a tie.
               if (mem_elig) begin
                  bus_cyc   <= 1'b1;
                  bus_we    <= mem_we;
                  bus_sel   <= mem_sel;
                  bus_adr   <= mem_addr;
                  bus_dat_o <= mem_wdata;
                  wd_cnt    <= 10'h0;
                  discard   <= 1'b0;
                  state     <= BUSY_MEM;
               end else if (if_elig) begin
                  bus_cyc   <= 1'b1;
                  bus_we    <= 1'b0;
                  bus_sel   <= 4'hF;
                  bus_adr   <= if_addr;
                  bus_dat_o <= 32'h0;
                  wd_cnt    <= 10'h0;
                  discard   <= 1'b0;
                  state     <= BUSY_IF;
               end
            end
            BUSY_IF, BUSY_MEM: begin
               if (done) begin
                  bus_cyc <= 1'b0;
                  discard <= 1'b0;
                  bus_err <= ~bus_ack;
                  state   <= IDLE;
                  // A flushed access still completes on the bus but is
                  // invisible to the pipeline.
                  if (!(discard | flush)) begin
                     if (state == BUSY_IF) begin
                        if_ready <= 1'b1;
                        if_rdata <= bus_ack ? bus_dat_i : ERR_DATA;
                     end else begin
                        mem_ready <= 1'b1;
                        if (!bus_ack)
                           mem_rdata <= ERR_DATA;
                        else
                           mem_rdata <= bus_we ? 32'h0 : bus_dat_i;
                     end
                  end
               end else begin
                  if (wd_cnt != WD_MAX)
                     wd_cnt <= wd_cnt + 10'd1;
                  if (flush)
                     discard <= 1'b1;
               end
            end
            default: begin
               bus_cyc <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
